// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous memory between the fetch (I) and load/store (D) ports.
// Build option ARB_ROUND_ROBIN_EN: ties alternate between ports instead of fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_d_q, owner_d_d;
  logic              store_q, store_d;
  logic              i_gnt_q, i_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              i_valid_q, i_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  // last_d_q resets to D so the first tie goes to I
  logic last_d_q, last_d_d;

  always_comb begin
    pick_d = (i_req && d_req) ? !last_d_q : d_req;
  end

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == ST_IDLE && (i_req || d_req)) begin
      last_d_d = pick_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d_d   = owner_d_q;
    store_d     = store_q;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d    = ST_ACCESS;
          cnt_d      = '0;
          owner_d_d  = pick_d;
          store_d    = pick_d && d_we;
          mem_en_d   = 1'b1;
          mem_we_d   = pick_d && d_we;
          mem_addr_d = pick_d ? d_addr : i_addr;
          if (pick_d) begin
            mem_wdata_d = d_wdata;
          end
          i_gnt_d    = !pick_d;
          d_gnt_d    = pick_d;
        end
      end
      ST_ACCESS: begin
        // Read data is captured on the last counted cycle so valid and rdata
        // appear together on the following (IDLE) cycle.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (owner_d_q) begin
            d_valid_d = 1'b1;
            if (!store_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            i_valid_d = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_d_q   <= 1'b0;
      store_q     <= 1'b0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_d_q   <= owner_d_d;
      store_q     <= store_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) !(i_gnt_q && d_gnt_q));
  a_we_with_en: assert property (@(posedge clk) disable iff (reset) !(mem_we_q && !mem_en_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: three instances (MEM_LAT 1, 2, 3) each checked every cycle
// against a transaction-level model that schedules gnt/valid/busy by cycle arithmetic.
module tb_mem_port_arbiter;

  localparam int CYCLES = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int LAT = g + 1;

    logic        reset, i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_valid, d_gnt, d_valid, mem_en, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        en_hist [0:2];
    logic [31:0] addr_hist [0:2];
    logic [31:0] junk;
    logic        rd_ok;
    logic [31:0] rd_addr;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rdata(i_rdata), .i_valid(i_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory model: data is only meaningful LAT-1 cycles after mem_en, junk otherwise
    always @(posedge clk) begin
      en_hist[0]   <= mem_en;
      en_hist[1]   <= en_hist[0];
      en_hist[2]   <= en_hist[1];
      addr_hist[0] <= mem_addr;
      addr_hist[1] <= addr_hist[0];
      addr_hist[2] <= addr_hist[1];
      junk         <= $urandom;
    end

    if (LAT == 1) begin : g_comb
      assign rd_ok   = mem_en;
      assign rd_addr = mem_addr;
    end else begin : g_pipe
      assign rd_ok   = en_hist[LAT-2];
      assign rd_addr = addr_hist[LAT-2];
    end
    assign mem_rdata = rd_ok ? mem_word(rd_addr) : junk;

    int          n, acc_a, free_at, mode;
    bit          acc_is_d, acc_we, last_d, fresh, rst_prev, win_d;
    logic [31:0] acc_addr, acc_wdata, exp_ir, exp_dr;
    bit          e_ig, e_dg, e_iv, e_dv, e_en, e_we, e_busy;

    function automatic string tg(input string s);
      return $sformatf("lat%0d c%0d %s", LAT, n, s);
    endfunction

    initial begin
      reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      rst_prev = 1'b1; acc_a = -1; free_at = 0; last_d = 1'b1; fresh = 1'b1;
      acc_is_d = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0; exp_ir = '0; exp_dr = '0;
      for (n = 0; n < CYCLES; n++) begin
        @(negedge clk);
        if (rst_prev) begin
          acc_a = -1; free_at = n; exp_ir = '0; exp_dr = '0; last_d = 1'b1; fresh = 1'b1;
        end
        e_en   = (acc_a == n);
        e_ig   = e_en && !acc_is_d;
        e_dg   = e_en && acc_is_d;
        e_we   = e_en && acc_we;
        e_iv   = (acc_a >= 0) && (n == acc_a + LAT) && !acc_is_d;
        e_dv   = (acc_a >= 0) && (n == acc_a + LAT) && acc_is_d;
        e_busy = (acc_a >= 0) && (n >= acc_a) && (n < acc_a + LAT);
        if (e_iv) exp_ir = mem_word(acc_addr);
        if (e_dv && !acc_we) exp_dr = mem_word(acc_addr);

        chk(tg("i_gnt"),   64'(i_gnt),   64'(e_ig));
        chk(tg("d_gnt"),   64'(d_gnt),   64'(e_dg));
        chk(tg("i_valid"), 64'(i_valid), 64'(e_iv));
        chk(tg("d_valid"), 64'(d_valid), 64'(e_dv));
        chk(tg("mem_en"),  64'(mem_en),  64'(e_en));
        chk(tg("mem_we"),  64'(mem_we),  64'(e_we));
        chk(tg("busy"),    64'(busy),    64'(e_busy));
        chk(tg("i_rdata"), 64'(i_rdata), 64'(exp_ir));
        chk(tg("d_rdata"), 64'(d_rdata), 64'(exp_dr));
        if (e_en) chk(tg("mem_addr"), 64'(mem_addr), 64'(acc_addr));
        if (e_we) chk(tg("mem_wdata"), 64'(mem_wdata), 64'(acc_wdata));
        if (fresh) begin
          chk(tg("mem_addr_rst"),  64'(mem_addr),  64'd0);
          chk(tg("mem_wdata_rst"), 64'(mem_wdata), 64'd0);
        end

        // Stimulus for this cycle: 0 mixed with resets, 1 both held, 2 D held only, 3 sparse
        mode = (n / 250) % 4;
        if (i_gnt || !i_req) i_addr = $urandom;
        if (d_gnt || !d_req) begin
          d_addr  = $urandom;
          d_we    = 1'($urandom_range(1));
          d_wdata = $urandom;
        end
        case (mode)
          1: begin i_req = 1'b1; d_req = 1'b1; end
          2: begin i_req = 1'b0; d_req = 1'b1; end
          default: begin
            if (i_req && !i_gnt) i_req = ($urandom_range(mode == 3 ? 3 : 15) != 0);
            else                 i_req = ($urandom_range(mode == 3 ? 5 : 2) == 0);
            if (d_req && !d_gnt) d_req = ($urandom_range(mode == 3 ? 3 : 15) != 0);
            else                 d_req = ($urandom_range(mode == 3 ? 5 : 2) == 0);
          end
        endcase
        reset = (n < 3) || (mode == 0 && $urandom_range(59) == 0);
        rst_prev = reset;

        if (!reset && n >= free_at && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
          win_d = (i_req && d_req) ? !last_d : d_req;
`else
          win_d = d_req;
`endif
          last_d    = win_d;
          acc_is_d  = win_d;
          acc_we    = win_d && d_we;
          acc_addr  = win_d ? d_addr : i_addr;
          acc_wdata = d_wdata;
          acc_a     = n + 1;
          free_at   = n + 1 + LAT;
          fresh     = 1'b0;
        end
      end
    end
  end

  initial begin
    repeat (CYCLES + 5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
